alu_muldiv_ctrl: RTL



---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_muldiv_iter.sv | 118 +++++++++++
 rtl/alu_muldiv_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU with iterative mul/div.
package alu_pkg;

  // 4-bit ALU control code, bit-compatible with the legacy combinational decoder
  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_SUB     = 4'b1000,
    ALU_SLL     = 4'b0001,
    ALU_SLT     = 4'b0010,
    ALU_SLTU    = 4'b0011,
    ALU_XOR     = 4'b0100,
    ALU_SRL     = 4'b0101,
    ALU_SRA     = 4'b1101,
    ALU_OR      = 4'b0110,
    ALU_AND     = 4'b0111,
    ALU_ILLEGAL = 4'b1111
  } alu_ctrl_e;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // M-extension ops, encoded as their funct3 value
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_MUL, ST_DIV, ST_HOLD
  } state_e;

  // funct3 to base ALU op when funct7 carries no modifier
  function automatic alu_ctrl_e base_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / divide datapath: radix-2 shift-add multiply and restoring
// division on operand magnitudes, one bit per cycle, signs restored at the end.
// done and res are valid combinationally in the final active cycle.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  logic            a_signed, b_signed, sa, sb, is_rem, by_zero, ovf;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;

  md_op_e          op_reg;
  logic [XLEN-1:0] hi_reg, lo_reg, dvs_reg, fast_res_reg;
  logic            neg_q_reg, neg_r_reg, fast_reg, active_reg, is_div_reg;
  logic [CW-1:0]   cnt_reg;

  logic [XLEN:0]     sum, shifted, diff;
  logic [XLEN-1:0]   hi_next, lo_next, q, r, iter_res;
  logic [2*XLEN-1:0] prod, prod_s;

  // Operand conditioning at start: magnitudes, result signs and divide fast paths
  always_comb begin
    a_signed = op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    b_signed = op inside {MD_MULH, MD_DIV, MD_REM};
    is_rem   = op inside {MD_REM, MD_REMU};
    sa       = a_signed & a[XLEN-1];
    sb       = b_signed & b[XLEN-1];
    mag_a    = sa ? -a : a;
    mag_b    = sb ? -b : b;
    by_zero  = (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) && (b == '0);
    ovf      = (op inside {MD_DIV, MD_REM}) && (a == MIN_VAL) && (b == '1);
    if (by_zero) fast_res = is_rem ? a : '1;
    else         fast_res = is_rem ? '0 : MIN_VAL;
  end

  // One iteration step: shift-add for multiply, trial subtract for divide
  always_comb begin
    sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, dvs_reg} : '0);
    shifted = {hi_reg, lo_reg[XLEN-1]};
    diff    = shifted - {1'b0, dvs_reg};
    if (is_div_reg) begin
      if (!diff[XLEN]) begin
        hi_next = diff[XLEN-1:0];
        lo_next = {lo_reg[XLEN-2:0], 1'b1};
      end else begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo_reg[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo_reg[XLEN-1:1]};
    end
  end

  // Sign fix-up and half/quotient/remainder selection on the final step
  always_comb begin
    prod   = {hi_next, lo_next};
    prod_s = neg_q_reg ? -prod : prod;
    q      = neg_q_reg ? -lo_next : lo_next;
    r      = neg_r_reg ? -hi_next : hi_next;
    case (op_reg)
      MD_MUL:                       iter_res = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: iter_res = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              iter_res = q;
      default:                      iter_res = r;
    endcase
    res  = fast_reg ? fast_res_reg : iter_res;
    done = active_reg && (fast_reg || (cnt_reg == CW'(XLEN-1)));
  end

  // Iteration registers: load on start, step while active, abort on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg       <= MD_MUL;
      hi_reg       <= '0;
      lo_reg       <= '0;
      dvs_reg      <= '0;
      fast_res_reg <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      fast_reg     <= 1'b0;
      is_div_reg   <= 1'b0;
      active_reg   <= 1'b0;
      cnt_reg      <= '0;
    end else if (start) begin
      op_reg       <= op;
      hi_reg       <= '0;
      lo_reg       <= mag_a;
      dvs_reg      <= mag_b;
      fast_res_reg <= fast_res;
      neg_q_reg    <= sa ^ sb;
      neg_r_reg    <= sa;
      fast_reg     <= by_zero || ovf;
      is_div_reg   <= op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
      active_reg   <= 1'b1;
      cnt_reg      <= '0;
    end else if (active_reg) begin
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
      cnt_reg <= cnt_reg + 1'b1;
      if (done) active_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// Execute-stage ALU: decodes ALUOp/funct3/funct7, runs base ops in one registered
// cycle and M-extension ops on the iterative unit, valid/ready on both sides.
module alu_muldiv_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1,
  parameter int SHAMT_W  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
);

  state_e          state_reg, state_next;
  alu_ctrl_e       ctrl;
  md_op_e          md_op;
  logic            is_m, accept, md_start, md_done;
  logic [XLEN-1:0] alu_res, md_res, result_reg;
  logic            illegal_reg;
  logic [SHAMT_W-1:0] shamt;

  assign accept   = in_valid && in_ready;
  assign md_start = accept && is_m;
  assign shamt    = op_b[SHAMT_W-1:0];
  assign result   = result_reg;
  assign illegal  = illegal_reg;

  // Decode alu_op/funct3/funct7 into a base control code or an M op
  always_comb begin
    ctrl  = ALU_ILLEGAL;
    is_m  = 1'b0;
    md_op = md_op_e'(funct3);
    case (alu_op)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_R: begin
        if (funct7 == FUNCT7_BASE) begin
          ctrl = base_ctrl(funct3);
        end else if (funct7 == FUNCT7_ALT) begin
          if (funct3 == 3'b000)      ctrl = ALU_SUB;
          else if (funct3 == 3'b101) ctrl = ALU_SRA;
        end else if ((ENABLE_M != 0) && (funct7 == FUNCT7_MULDIV)) begin
          is_m = 1'b1;
        end
      end
      default: begin
        // I-type: funct7 is the upper immediate except for shifts
        if (funct3 == 3'b001) begin
          if (funct7 == FUNCT7_BASE) ctrl = ALU_SLL;
        end else if (funct3 == 3'b101) begin
          if (funct7 == FUNCT7_BASE)     ctrl = ALU_SRL;
          else if (funct7 == FUNCT7_ALT) ctrl = ALU_SRA;
        end else begin
          ctrl = base_ctrl(funct3);
        end
      end
    endcase
  end

  // Single-cycle base ALU; illegal codes produce zero
  always_comb begin
    alu_res = '0;
    case (ctrl)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  generate
    if (ENABLE_M != 0) begin : g_md
      alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk   (clk),
        .reset (reset),
        .start (md_start),
        .op    (md_op),
        .a     (op_a),
        .b     (op_b),
        .done  (md_done),
        .res   (md_res)
      );
    end else begin : g_no_md
      assign md_done = 1'b0;
      assign md_res  = '0;
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // FSM next-state: accept from IDLE or a draining HOLD, wait on the iterator
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          if (!is_m)          state_next = ST_HOLD;
          else if (funct3[2]) state_next = ST_DIV;
          else                state_next = ST_MUL;
        end else if ((state_reg == ST_HOLD) && out_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: if (md_done) state_next = ST_HOLD;
      default:        state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake and busy flags
  always_comb begin
    in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && out_ready);
    busy      = (state_reg == ST_MUL) || (state_reg == ST_DIV);
    out_valid = (state_reg == ST_HOLD);
  end

  // Result register: loaded on base-op acceptance or iterator completion, held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      result_reg  <= '0;
      illegal_reg <= 1'b0;
    end else if (accept && !is_m) begin
      result_reg  <= alu_res;
      illegal_reg <= (ctrl == ALU_ILLEGAL);
    end else if (busy && md_done) begin
      result_reg  <= md_res;
      illegal_reg <= 1'b0;
    end
  end

endmodule
